// File: rtl/instr_encoder.sv
// Packs decoded Frost32 instruction fields into 32-bit words behind a 2-entry output FIFO.
// Optional err_count output enabled by defining FROST32_INSTR_ENCODER_ERR_COUNT_EN.
module instr_encoder #(
    parameter int WORD_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_group,
    input  logic [3:0]             in_ra_index,
    input  logic [3:0]             in_rb_index,
    input  logic [3:0]             in_rc_index,
    input  logic [3:0]             in_opcode,
    input  logic [15:0]            in_imm_val,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_WIDTH-1:0]  out_word,
    output logic                   out_err,
    output logic [COUNT_WIDTH-1:0] enc_count
`ifdef FROST32_INSTR_ENCODER_ERR_COUNT_EN
    ,
    output logic [7:0]             err_count
`endif
);

    logic [WORD_WIDTH-1:0]  head_word_q, head_word_d;
    logic                   head_err_q, head_err_d;
    logic [WORD_WIDTH-1:0]  tail_word_q, tail_word_d;
    logic                   tail_err_q, tail_err_d;
    logic [1:0]             count_q, count_d;
    logic [COUNT_WIDTH-1:0] enc_count_q, enc_count_d;

    logic [WORD_WIDTH-1:0]  new_word;
    logic                   new_err;
    logic                   push;
    logic                   pop;

    // Field packing; unencodable groups collapse to an all-zero NOP word.
    always_comb begin
        new_word = '0;
        new_err  = 1'b0;
        case (in_group)
            4'd0, 4'd3, 4'd4, 4'd6: begin
                new_word = {in_group, in_ra_index, in_rb_index, in_rc_index, 12'h000, in_opcode};
            end
            4'd1, 4'd2: begin
                new_word = {in_group, in_ra_index, in_rb_index, in_opcode, in_imm_val};
            end
            4'd5: begin
                new_word = {in_group, in_ra_index, in_rb_index, in_rc_index, in_opcode,
                            in_imm_val[11:0]};
                new_err  = (in_imm_val[15:12] != {4{in_imm_val[11]}});
            end
            default: begin
                new_word = '0;
                new_err  = 1'b1;
            end
        endcase
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        head_word_d = head_word_q;
        head_err_d  = head_err_q;
        tail_word_d = tail_word_q;
        tail_err_d  = tail_err_q;
        count_d     = count_q;
        enc_count_d = enc_count_q + (pop ? COUNT_WIDTH'(1) : COUNT_WIDTH'(0));
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_word_d = new_word;
                    head_err_d  = new_err;
                    count_d     = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_word_d = new_word;
                    head_err_d  = new_err;
                end else if (push) begin
                    tail_word_d = new_word;
                    tail_err_d  = new_err;
                    count_d     = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                // Full: in_ready is low, so only a pop can happen here.
                if (pop) begin
                    head_word_d = tail_word_q;
                    head_err_d  = tail_err_q;
                    count_d     = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_word_q <= '0;
            head_err_q  <= 1'b0;
            tail_word_q <= '0;
            tail_err_q  <= 1'b0;
            count_q     <= 2'd0;
            enc_count_q <= '0;
        end else begin
            head_word_q <= head_word_d;
            head_err_q  <= head_err_d;
            tail_word_q <= tail_word_d;
            tail_err_q  <= tail_err_d;
            count_q     <= count_d;
            enc_count_q <= enc_count_d;
        end
    end

    assign out_word  = head_word_q;
    assign out_err   = head_err_q;
    assign enc_count = enc_count_q;

`ifdef FROST32_INSTR_ENCODER_ERR_COUNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (pop && head_err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_q <= 8'h00;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: encoding, errors, backpressure,
// streaming, enc_count wrap and mid-operation reset.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_group;
    logic [3:0]  in_ra_index;
    logic [3:0]  in_rb_index;
    logic [3:0]  in_rc_index;
    logic [3:0]  in_opcode;
    logic [15:0] in_imm_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_err;
    logic [15:0] enc_count;
`ifdef FROST32_INSTR_ENCODER_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    int n_checks;
    int n_fail;

    instr_encoder #(.WORD_WIDTH(32), .COUNT_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_group    (in_group),
        .in_ra_index (in_ra_index),
        .in_rb_index (in_rb_index),
        .in_rc_index (in_rc_index),
        .in_opcode   (in_opcode),
        .in_imm_val  (in_imm_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_err     (out_err),
        .enc_count   (enc_count)
`ifdef FROST32_INSTR_ENCODER_ERR_COUNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0]  g;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
        logic [3:0]  op;
        logic [15:0] imm;
        logic [31:0] exp_word;
        logic        exp_err;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [3:0] g, input logic [3:0] ra, input logic [3:0] rb,
                              input logic [3:0] rc, input logic [3:0] op, input logic [15:0] imm);
        in_group    = g;
        in_ra_index = ra;
        in_rb_index = rb;
        in_rc_index = rc;
        in_opcode   = op;
        in_imm_val  = imm;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_fields(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: out_valid=%b in_ready=%b out_err=%b, want 0 1 0",
                     out_valid, in_ready, out_err);
        end
        n_checks++;
        if (out_word !== 32'h0 || enc_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_values: out_word=%h enc_count=%h, want 0 0", out_word, enc_count);
        end
`ifdef FROST32_INSTR_ENCODER_ERR_COUNT_EN
        n_checks++;
        if (err_count !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_err_count: got %h want 00", err_count);
        end
`endif
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_encoding();
        vec_t vecs[9];
        vecs = '{
            '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 16'h0000, 32'h0123_0004, 1'b0},
            '{4'h1, 4'h5, 4'h6, 4'hF, 4'h2, 16'hBEEF, 32'h1562_BEEF, 1'b0},
            '{4'h5, 4'h1, 4'h2, 4'h3, 4'h1, 16'hFFF0, 32'h5123_1FF0, 1'b0},
            '{4'h5, 4'h1, 4'h2, 4'h3, 4'h1, 16'h0800, 32'h5123_1800, 1'b1},
            '{4'h7, 4'h9, 4'h9, 4'h9, 4'h9, 16'h1234, 32'h0000_0000, 1'b1},
            '{4'h3, 4'hA, 4'hB, 4'hC, 4'hD, 16'hFFFF, 32'h3ABC_000D, 1'b0},
            '{4'h2, 4'h0, 4'hF, 4'h7, 4'hE, 16'h7FFF, 32'h20FE_7FFF, 1'b0},
            '{4'h5, 4'h4, 4'h3, 4'h2, 4'hF, 16'h07FF, 32'h5432_F7FF, 1'b0},
            '{4'hF, 4'h1, 4'h1, 4'h1, 4'h1, 16'hAAAA, 32'h0000_0000, 1'b1}
        };
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_fields(vecs[i].g, vecs[i].ra, vecs[i].rb, vecs[i].rc, vecs[i].op, vecs[i].imm);
            in_valid  = 1'b1;
            out_ready = 1'b0;
            tick();
            in_valid = 1'b0;
            $display("encode vec %0d group %0d word %h err %b", i, vecs[i].g, out_word, out_err);
            n_checks++;
            if (out_valid !== 1'b1 || out_word !== vecs[i].exp_word || out_err !== vecs[i].exp_err) begin
                n_fail++;
                $display("FAIL encode_%0d: valid=%b word=%h err=%b, want 1 %h %b",
                         i, out_valid, out_word, out_err, vecs[i].exp_word, vecs[i].exp_err);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0 || enc_count !== 16'(i + 1)) begin
                n_fail++;
                $display("FAIL encode_pop_%0d: valid=%b enc_count=%0d, want 0 %0d",
                         i, out_valid, enc_count, i + 1);
            end
        end
`ifdef FROST32_INSTR_ENCODER_ERR_COUNT_EN
        n_checks++;
        if (err_count !== 8'd3) begin
            n_fail++;
            $display("FAIL err_count: got %0d want 3", err_count);
        end
`endif
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        set_fields(4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 16'h0000);
        in_valid = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_word !== 32'h0111_0001) begin
            n_fail++;
            $display("FAIL bp_first: in_ready=%b word=%h, want 1 01110001", in_ready, out_word);
        end
        set_fields(4'h1, 4'h2, 4'h3, 4'h0, 4'h4, 16'h5555);
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_word !== 32'h0111_0001) begin
            n_fail++;
            $display("FAIL bp_full: in_ready=%b word=%h, want 0 01110001", in_ready, out_word);
        end
        set_fields(4'h4, 4'h7, 4'h8, 4'h9, 4'hA, 16'h0000);
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_word !== 32'h0111_0001) begin
            n_fail++;
            $display("FAIL bp_hold: in_ready=%b valid=%b word=%h, want 0 1 01110001",
                     in_ready, out_valid, out_word);
        end
        out_ready = 1'b1;
        tick();
        $display("bp pop 1 word %h", out_word);
        n_checks++;
        if (in_ready !== 1'b1 || out_word !== 32'h1234_5555) begin
            n_fail++;
            $display("FAIL bp_pop1: in_ready=%b word=%h, want 1 12345555", in_ready, out_word);
        end
        tick();
        in_valid = 1'b0;
        $display("bp pop 2 word %h", out_word);
        n_checks++;
        if (out_valid !== 1'b1 || out_word !== 32'h4789_000A) begin
            n_fail++;
            $display("FAIL bp_pop2: valid=%b word=%h, want 1 4789000a", out_valid, out_word);
        end
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || enc_count !== 16'd3) begin
            n_fail++;
            $display("FAIL bp_done: valid=%b enc_count=%0d, want 0 3", out_valid, enc_count);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_word;
        do_reset();
        set_fields(4'h6, 4'hF, 4'hF, 4'hF, 4'hF, 16'h0000);
        in_valid = 1'b1;
        tick();
        exp_word = 32'h6FFF_000F;
        for (int i = 0; i < 10; i++) begin
            set_fields(4'h0, 4'(i), 4'h0, 4'h0, 4'h0, 16'h0000);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_word !== exp_word) begin
                n_fail++;
                $display("FAIL stream_%0d: valid=%b in_ready=%b word=%h, want 1 1 %h",
                         i, out_valid, in_ready, out_word, exp_word);
            end
            tick();
            $display("stream beat %0d word %h", i, out_word);
            exp_word = {4'h0, 4'(i), 24'h0};
        end
        n_checks++;
        if (enc_count !== 16'd10 || out_word !== exp_word) begin
            n_fail++;
            $display("FAIL stream_count: enc_count=%0d word=%h, want 10 %h", enc_count, out_word, exp_word);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || enc_count !== 16'd11) begin
            n_fail++;
            $display("FAIL stream_drain: valid=%b enc_count=%0d, want 0 11", out_valid, enc_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_fields(4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 16'h0000);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (65536) tick();
        n_checks++;
        if (enc_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_max: enc_count=%h want ffff", enc_count);
        end
        tick();
        n_checks++;
        if (enc_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_zero: enc_count=%h want 0000", enc_count);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        $display("wrap done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_fields(4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 16'h0000);
        in_valid = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        set_fields(4'h5, 4'h1, 4'h2, 4'h3, 4'h1, 16'h0800);
        in_valid = 1'b1;
        tick();
        set_fields(4'h1, 4'h5, 4'h6, 4'h0, 4'h2, 16'hBEEF);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || out_err !== 1'b1 || enc_count !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_prefill: in_ready=%b err=%b enc_count=%0d, want 0 1 1",
                     in_ready, out_err, enc_count);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || enc_count !== 16'd0 ||
            out_word !== 32'h0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b in_ready=%b enc=%0d word=%h err=%b, want 0 1 0 0 0",
                     out_valid, in_ready, enc_count, out_word, out_err);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after: valid=%b want 0", out_valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_encoding();
        test_backpressure();
        test_streaming();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decoder: accepts decoded instruction fields (group, register indices, opcode, immediate) and packs them into 32-bit Frost32 instruction words.
- Used by the debug/instruction-injection path to build instruction words in hardware and push them into the fetch-side injection queue.
- Valid/ready input side, a 2-entry output FIFO, error flagging for unencodable requests, and a running count of emitted words.

Parameters:
- WORD_WIDTH, 32, instruction word width; fixed, must be 32.
- COUNT_WIDTH, 16, width of enc_count.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  field bundle present.
- in_ready  output  1  encoder can accept a bundle this cycle.
- in_group  input  4  instruction group (0..6 legal).
- in_ra_index  input  4  rA.
- in_rb_index  input  4  rB.
- in_rc_index  input  4  rC.
- in_opcode  input  4  opcode within group.
- in_imm_val  input  16  immediate (groups 1, 2, 5).
- out_valid  output  1  word available.
- out_ready  input  1  consumer takes word.
- out_word  output  32  encoded instruction.
- out_err  output  1  word at head was produced from an unencodable bundle.
- enc_count  output  COUNT_WIDTH  words consumed since reset.

Behaviour:
- Single clock, synchronous active-low reset on rst_n, sampled on the rising edge of clk.
- Reset values: out_valid=0, out_word=0, out_err=0, enc_count=0, FIFO empty, in_ready=1 in the first cycle after reset.
- Encoding, bit positions:
  - All groups: group [31:28], ra [27:24], rb [23:20].
  - Groups 0, 3, 4, 6: rc [19:16], [15:4]=0, opcode [3:0]. in_imm_val is ignored.
  - Groups 1, 2: opcode [19:16], imm [15:0]. in_rc_index is ignored.
  - Group 5: rc [19:16], opcode [15:12], imm12 [11:0]=in_imm_val[11:0].
- Error rules:
  - Group 5 with in_imm_val[15:12] not equal to 4 copies of in_imm_val[11]: word is still encoded (truncated); err=1.
  - Group 7..15: word is forced to 32'h0000_0000 (NOP); err=1.
  - err is stored alongside the word in the FIFO.
- Handshake:
  - Input accepted when in_valid&&in_ready. Output consumed when out_valid&&out_ready.
  - out_word/out_err must hold stable while out_valid&&!out_ready.
- FIFO:
  - 2 entries with a registered occupancy count. in_ready=(count!=2); no combinational path from out_ready to in_ready.
  - out_valid=(count!=0). out_word/out_err are the head entry, driven from registers.
- Latency: accept in cycle N, word visible at out_valid in cycle N+1 when the FIFO was empty.
- Simultaneous accept and consume:
  - count unchanged.
  - At count=1: the head is replaced by the new word in the next cycle.
  - At count=2: accept cannot occur (in_ready=0); consume only.
- Ordering: strictly FIFO; no reordering, no drops.
- enc_count increments by 1 on each output handshake and wraps from 2^COUNT_WIDTH-1 to 0.
- Reset asserted mid-operation: the FIFO is discarded and all outputs return to reset values on the next edge. Held words are lost; that is intended.
- in_* fields are don't-care while in_valid=0.

Optional Feature:
- Macro: FROST32_INSTR_ENCODER_ERR_COUNT_EN.
- Defined:
  - Adds output err_count [7:0], reset 0.
  - Increments on each output handshake with out_err=1; saturates at 8'hFF (no wrap).
- Undefined: port absent; no counter logic; all other behaviour identical.

Test Plan:
- Reset released, group0 ra=1 rb=2 rc=3 op=4, out_ready=1 -> next cycle out_valid=1, out_word=32'h0123_0004, out_err=0, enc_count=1 after consume.
- Group1 ra=5 rb=6 op=2 imm=16'hBEEF -> out_word=32'h5621_BEEF? No: 32'h1562_BEEF, out_err=0. Group5 ra=1 rb=2 rc=3 op=1 imm=16'hFFF0 -> 32'h5123_1FF0, err=0.
- Group5 imm=16'h0800 -> out_word=32'h5123_1800 (same fields), out_err=1. Group 7 any fields -> out_word=32'h0000_0000, out_err=1. With macro defined, err_count=2.
- out_ready=0, offer 3 bundles back-to-back -> in_ready low after 2 accepts and the third held; head stable. Raise out_ready -> words emerge in order, third accepted the cycle after the first pop, enc_count=3.
- Steady streaming at count=1 with in_valid=out_ready=1 for 10 cycles -> one word per cycle, count stays 1, enc_count=10. Preload enc_count to 16'hFFFF via 65535 words -> next handshake wraps it to 0.
- FIFO full with out_ready=0, assert rst_n=0 one cycle -> next cycle out_valid=0, in_ready=1, enc_count=0, out_word=0.
